load_wb_unit: RTL and testbench
===============================

Name: load_wb_unit

Overview:
- Write-back stage feeding the register file write port (reg_write_ena / write_addr / write_data) of the single-cycle core.
- Forwards ALU results combinationally.
- For loads: freezes the core, runs a single-beat AXI4 read, extracts and extends the addressed bytes, then writes rd.
- Sits between execute and registers, and owns the AXI4 AR/R channels of the data port.

Parameters:
- XLEN, 64: register and AXI data width.
- ADDR_W, 64: AXI address width.
- AXI_ID, 0: constant arid value.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- load_valid  in  1  execute presents a load this cycle.
- load_addr  in  ADDR_W  effective address.
- load_funct3  in  3  LB=000 LH=001 LW=010 LD=011 LBU=100 LHU=101 LWU=110.
- load_rd  in  5  load destination.
- alu_wb_valid  in  1  ALU result to write.
- alu_rd  in  5  ALU destination.
- alu_data  in  XLEN  ALU result.
- stall  out  1  freeze PC/fetch.
- reg_write_ena  out  1  to register file.
- write_addr  out  5  to register file.
- write_data  out  XLEN  to register file.
- load_misalign  out  1  misaligned-load exception pulse.
- load_fault  out  1  bus error pulse (see Optional Feature).
- araddr  out  ADDR_W  AXI read address.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- arid  out  4  AXI AR id.
- arlen  out  8  AXI burst length.
- arsize  out  3  AXI beat size.
- arburst  out  2  AXI burst type.
- rdata  in  XLEN  AXI read data.
- rresp  in  2  AXI read response.
- rlast  in  1  AXI last beat.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE.
  - Latched addr/funct3/rd/data are cleared to 0.
  - All outputs are 0.
  - An in-flight AXI transaction is abandoned; the slave shares rst.
- Constant AR fields: arid=AXI_ID, arlen=0, arsize=3'b011, arburst=INCR (2'b01). araddr = {addr[ADDR_W-1:3],3'b000}.
- FSM has four states: IDLE, AR, R, WB.
- IDLE:
  - Misaligned case: load_valid and misaligned (LH/LHU addr[0]!=0; LW/LWU addr[1:0]!=0; LD addr[2:0]!=0). Combinationally load_misalign=1, stall=0, no write, no AXI traffic, stay IDLE.
  - Aligned case: load_valid and aligned. Combinationally stall=1; latch addr, funct3, rd; next state AR. The ALU path is ignored this cycle.
  - Otherwise: reg_write_ena = alu_wb_valid & (alu_rd!=0), write_addr=alu_rd, write_data=alu_data, all combinational.
  - funct3=111 is treated as LD.
- AR: arvalid=1 and stall=1. arvalid stays high until arready; araddr is stable throughout. Go to R on arvalid&arready.
- R: rready=1 and stall=1. On rvalid: capture rdata and rresp, go to WB. rlast is not checked; arlen=0 guarantees a single beat.
- WB (exactly one cycle), then go to IDLE:
  - stall=0.
  - reg_write_ena = (rd!=0).
  - write_addr=rd.
  - write_data = extend(captured_data >> (addr[2:0]*8), funct3).
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU; LD passes through.
- Alignment of R to WB: the core holds its inputs while stall=1, so the load that completes in WB is the one latched.
- Timing: minimum latency is load_valid at cycle N, AR handshake N+1, R beat N+2, write at N+3. stall is high for N..N+2.
- Write of x0 is never issued, on either the load path or the ALU path.
- alu_wb_valid is ignored outside IDLE.

Optional Feature:
- Macro: LOAD_RESP_CHECK_EN.
- Defined:
  - If captured rresp is SLVERR (10) or DECERR (11), WB pulses load_fault=1 for one cycle and reg_write_ena=0.
  - OKAY and EXOKAY write normally.
- Undefined: load_fault is tied 0, rresp is ignored, and data is always written.

Decomposition:
- Shared package holds:
  - funct3 load codes.
  - FSM state encoding (IDLE/AR/R/WB).
  - AXI constants (SIZE_8B, BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR).
- One natural combinational sub-module: load_extend. Inputs are data, byte offset and funct3; output is the XLEN result. It is reused by the future store/AMO path.

Test Plan:
- ALU pass-through: alu_wb_valid=1, alu_rd=5, alu_data=0x1234 in IDLE -> reg_write_ena=1, write_addr=5, write_data=0x1234 the same cycle, stall=0.
- LB sign-extend: LB addr=0x8000_0003, rd=7, rdata=0x0000_0000_8000_0000 with arready and rvalid held high -> araddr=0x8000_0000, stall high for 3 cycles, write x7=0xFFFF_FFFF_FFFF_FF80 on cycle N+3.
- LWU zero-extend with backpressure: LWU addr=0x8000_0004, rdata=0xDEAD_BEEF_0000_0001, arready delayed 3 cycles, rvalid delayed 2 cycles -> arvalid/araddr stable throughout, write_data=0x0000_0000_DEAD_BEEF, stall released only in WB.
- Misalign and x0 suppression: LW addr=0x8000_0002 -> load_misalign pulse, no arvalid, no write. Separately, LD with rd=0 -> full AXI read, reg_write_ena stays 0.
- Reset mid-read: rst low while in R -> immediate IDLE, stall=0, arvalid=rready=0. The next load after release runs normally.
- Bus error (LOAD_RESP_CHECK_EN defined): rresp=2'b10 -> load_fault=1 in WB, no register write. With the macro undefined, the same stimulus writes rdata.

Source files
------------

// File: rtl/load_wb_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_wb_unit_pkg
// Description : Shared load funct3 codes, write-back FSM encoding, AXI
//               constants and the load alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package load_wb_unit_pkg;

  // RISC-V load funct3 codes; 3'b111 is unused by the ISA and treated as LD
  localparam logic [2:0] c_F3_LB     = 3'b000;
  localparam logic [2:0] c_F3_LH     = 3'b001;
  localparam logic [2:0] c_F3_LW     = 3'b010;
  localparam logic [2:0] c_F3_LD     = 3'b011;
  localparam logic [2:0] c_F3_LBU    = 3'b100;
  localparam logic [2:0] c_F3_LHU    = 3'b101;
  localparam logic [2:0] c_F3_LWU    = 3'b110;
  localparam logic [2:0] c_F3_LD_ALT = 3'b111;

  // Write-back FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // AXI4 constants
  localparam logic [2:0] c_AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] c_AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] c_AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] c_AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_AXI_RESP_DECERR = 2'b11;

  // A load is misaligned when its natural size does not divide the offset
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    logic r;
    case (f3)
      c_F3_LH, c_F3_LHU:     r = off[0];
      c_F3_LW, c_F3_LWU:     r = |off[1:0];
      c_F3_LD, c_F3_LD_ALT:  r = |off;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_wb_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Selects the addressed bytes of a doubleword bus beat and
//               sign/zero-extends them according to the load funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
  import load_wb_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [2:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shifted;

  // Bring the addressed byte down to bit 0
  assign w_shifted = i_data >> {i_offset, 3'b000};

  // Extend the selected field; LD and the unused 3'b111 code pass through
  always_comb begin
    o_data = w_shifted;
    case (i_funct3)
      c_F3_LB:  o_data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      c_F3_LH:  o_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      c_F3_LW:  o_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      c_F3_LBU: o_data = {{(XLEN-8){1'b0}},           w_shifted[7:0]};
      c_F3_LHU: o_data = {{(XLEN-16){1'b0}},          w_shifted[15:0]};
      c_F3_LWU: o_data = {{(XLEN-32){1'b0}},          w_shifted[31:0]};
      default:  o_data = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_wb_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_wb_unit
// Description : Write-back stage. Forwards ALU results combinationally and
//               runs single-beat AXI4 reads for loads while stalling the core.
//               Optional macro LOAD_RESP_CHECK_EN: SLVERR/DECERR responses
//               raise load_fault and suppress the register write.
// Revision    : 1.0 - initial release
// ============================================================================
module load_wb_unit
  import load_wb_unit_pkg::*;
#(
  parameter int         XLEN   = 64,
  parameter int         ADDR_W = 64,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [2:0]        load_funct3,
  input  logic [4:0]        load_rd,
  input  logic              alu_wb_valid,
  input  logic [4:0]        alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              stall,
  output logic              reg_write_ena,
  output logic [4:0]        write_addr,
  output logic [XLEN-1:0]   write_data,
  output logic              load_misalign,
  output logic              load_fault,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic [XLEN-1:0]   rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_data;
  logic [1:0]        r_resp;
  logic              w_misaligned;
  logic              w_accept;
  logic              w_resp_err;
  logic [XLEN-1:0]   w_ext;
  logic              w_unused;

  assign w_misaligned = is_misaligned(load_funct3, load_addr[2:0]);

`ifdef LOAD_RESP_CHECK_EN
  assign w_resp_err = (r_resp == c_AXI_RESP_SLVERR) || (r_resp == c_AXI_RESP_DECERR);
`else
  assign w_resp_err = 1'b0;
`endif

  // rlast is redundant with arlen=0; r_resp is only consulted with the check enabled
  assign w_unused = ^{rlast, r_resp};

  // Constant AR fields; everything reads 0 while reset is asserted
  assign araddr  = {r_addr[ADDR_W-1:3], 3'b000};
  assign arid    = rst ? AXI_ID           : 4'd0;
  assign arlen   = 8'd0;
  assign arsize  = rst ? c_AXI_SIZE_8B    : 3'b000;
  assign arburst = rst ? c_AXI_BURST_INCR : 2'b00;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_data   (r_data),
    .i_offset (r_addr[2:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_ext)
  );

  // State register plus load context latched at accept and beat capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_funct3 <= 3'b000;
      r_rd     <= 5'd0;
      r_data   <= '0;
      r_resp   <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr   <= load_addr;
        r_funct3 <= load_funct3;
        r_rd     <= load_rd;
      end
      if (r_state == ST_R && rvalid) begin
        r_data <= rdata;
        r_resp <= rresp;
      end
    end
  end

  // Next state and all handshake/write-port outputs; reset forces them low
  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    stall         = 1'b0;
    reg_write_ena = 1'b0;
    write_addr    = 5'd0;
    write_data    = '0;
    load_misalign = 1'b0;
    load_fault    = 1'b0;
    arvalid       = 1'b0;
    rready        = 1'b0;
    if (rst) begin
      case (r_state)
        ST_IDLE: begin
          if (load_valid && w_misaligned) begin
            load_misalign = 1'b1;
          end else if (load_valid) begin
            stall    = 1'b1;
            w_accept = 1'b1;
            w_next   = ST_AR;
          end else begin
            reg_write_ena = alu_wb_valid && (alu_rd != 5'd0);
            write_addr    = alu_rd;
            write_data    = alu_data;
          end
        end
        ST_AR: begin
          stall   = 1'b1;
          arvalid = 1'b1;
          if (arready) w_next = ST_R;
        end
        ST_R: begin
          stall  = 1'b1;
          rready = 1'b1;
          if (rvalid) w_next = ST_WB;
        end
        default: begin
          reg_write_ena = (r_rd != 5'd0) && !w_resp_err;
          load_fault    = w_resp_err;
          write_addr    = r_rd;
          write_data    = w_ext;
          w_next        = ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_wb_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_wb_unit
// Description : Self-checking bench for load_wb_unit with a write-back
//               scoreboard fed by directed load/ALU vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_wb_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [63:0] load_addr = '0;
  logic [2:0]  load_funct3 = '0;
  logic [4:0]  load_rd = '0;
  logic        alu_wb_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [63:0] alu_data = '0;
  logic        stall, reg_write_ena, load_misalign, load_fault;
  logic [4:0]  write_addr;
  logic [63:0] write_data;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b1;
  logic        rvalid = 1'b0;
  logic        rready;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        is_fault;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  load_wb_unit dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_addr(load_addr), .load_funct3(load_funct3), .load_rd(load_rd),
    .alu_wb_valid(alu_wb_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .stall(stall), .reg_write_ena(reg_write_ena), .write_addr(write_addr), .write_data(write_data),
    .load_misalign(load_misalign), .load_fault(load_fault),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [4:0] rd, input logic [63:0] data);
    exp_t e;
    e.is_fault = 1'b0; e.rd = rd; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_fault();
    exp_t e;
    e.is_fault = 1'b1; e.rd = 5'd0; e.data = 64'd0;
    exp_q.push_back(e);
  endtask

  // Monitor: every write-back or fault event is matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reg_write_ena === 1'b1 || load_fault === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_wb ena=%b fault=%b addr=%0d data=0x%h expected=none t=%0t",
                 reg_write_ena, load_fault, write_addr, write_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (e.is_fault) begin
          if (!(load_fault === 1'b1 && reg_write_ena === 1'b0)) begin
            failures++;
            $display("FAIL wb_fault ena=%b fault=%b expected ena=0 fault=1 t=%0t",
                     reg_write_ena, load_fault, $time);
          end
        end else if (!(reg_write_ena === 1'b1 && load_fault === 1'b0 &&
                       write_addr === e.rd && write_data === e.data)) begin
          failures++;
          $display("FAIL wb_write ena=%b fault=%b addr=%0d data=0x%h expected addr=%0d data=0x%h t=%0t",
                   reg_write_ena, load_fault, write_addr, write_data, e.rd, e.data, $time);
        end
      end
    end
  end

  // Full load sequence with optional AR/R backpressure; the ALU port carries
  // a live x9 write throughout, which must be ignored until WB completes
  task automatic do_load(input logic [2:0] f3, input logic [63:0] addr, input logic [4:0] rd,
                         input logic [63:0] data, input logic [1:0] resp,
                         input int ar_dly, input int r_dly);
    load_valid = 1'b1; load_addr = addr; load_funct3 = f3; load_rd = rd;
    alu_wb_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'hBAD0;
    @(negedge clk);
    chk1("issue_stall", stall, 1'b1);
    chk1("issue_arvalid", arvalid, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i <= ar_dly; i++) begin
      arready = (i == ar_dly);
      @(negedge clk);
      chk1("ar_valid", arvalid, 1'b1);
      chk64("ar_addr", araddr, addr & ~64'h7);
      chk1("ar_stall", stall, 1'b1);
      @(posedge clk); #1;
    end
    arready = 1'b0;
    for (int j = 0; j <= r_dly; j++) begin
      rvalid = (j == r_dly);
      rdata  = (j == r_dly) ? data : 64'hFFFF_0000_FFFF_0000;
      rresp  = resp;
      @(negedge clk);
      chk1("r_ready", rready, 1'b1);
      chk1("r_stall", stall, 1'b1);
      chk1("r_arvalid", arvalid, 1'b0);
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rresp = 2'b00; load_valid = 1'b0; alu_wb_valid = 1'b0;
    @(negedge clk);
    chk1("wb_stall", stall, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic do_misalign(input logic [2:0] f3, input logic [63:0] addr);
    load_valid = 1'b1; load_addr = addr; load_funct3 = f3; load_rd = 5'd3;
    @(negedge clk);
    chk1("mis_pulse", load_misalign, 1'b1);
    chk1("mis_stall", stall, 1'b0);
    chk1("mis_arvalid", arvalid, 1'b0);
    @(posedge clk); #1;
    load_valid = 1'b0;
    @(negedge clk);
    chk1("mis_idle_arvalid", arvalid, 1'b0);
    chk1("mis_idle_pulse", load_misalign, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a load presented to prove outputs stay low
    load_valid = 1'b1; load_addr = 64'h8; load_funct3 = 3'b011;
    #12;
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_wena", reg_write_ena, 1'b0);
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk64("rst_araddr", araddr, 64'd0);
    load_valid = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk64("ar_const_size", {61'd0, arsize}, 64'd3);
    chk64("ar_const_burst", {62'd0, arburst}, 64'd1);
    chk64("ar_const_len", {56'd0, arlen}, 64'd0);
    chk64("ar_const_id", {60'd0, arid}, 64'd0);

    // ALU pass-through, then x0 suppression on the ALU path
    alu_wb_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    push_wr(5'd5, 64'h1234);
    @(negedge clk);
    chk1("alu_stall", stall, 1'b0);
    @(posedge clk); #1;
    alu_rd = 5'd0; alu_data = 64'h55;
    @(posedge clk); #1;
    alu_wb_valid = 1'b0;

    // Loads of every width and extension
    push_wr(5'd7,  64'hFFFF_FFFF_FFFF_FF80);
    do_load(3'b000, 64'h8000_0003, 5'd7,  64'h0000_0000_8000_0000, 2'b00, 0, 0);
    push_wr(5'd8,  64'h0000_0000_DEAD_BEEF);
    do_load(3'b110, 64'h8000_0004, 5'd8,  64'hDEAD_BEEF_0000_0001, 2'b00, 3, 2);
    push_wr(5'd10, 64'hFFFF_FFFF_FFFF_8001);
    do_load(3'b001, 64'h8000_0006, 5'd10, 64'h8001_0000_0000_0000, 2'b00, 0, 1);
    push_wr(5'd11, 64'h0000_0000_0000_8001);
    do_load(3'b101, 64'h8000_0006, 5'd11, 64'h8001_0000_0000_0000, 2'b00, 1, 0);
    push_wr(5'd12, 64'hFFFF_FFFF_8765_4321);
    do_load(3'b010, 64'h8000_0000, 5'd12, 64'h0000_0000_8765_4321, 2'b00, 0, 0);
    push_wr(5'd13, 64'h0123_4567_89AB_CDEF);
    do_load(3'b011, 64'h8000_0008, 5'd13, 64'h0123_4567_89AB_CDEF, 2'b01, 0, 0);
    push_wr(5'd14, 64'h0000_0000_0000_00AB);
    do_load(3'b100, 64'h8000_0005, 5'd14, 64'h0000_AB00_0000_0000, 2'b00, 0, 0);
    push_wr(5'd15, 64'hFEDC_BA98_7654_3210);
    do_load(3'b111, 64'h8000_0010, 5'd15, 64'hFEDC_BA98_7654_3210, 2'b00, 0, 0);

    // Misaligned loads never reach the bus or the register file
    do_misalign(3'b010, 64'h8000_0002);
    do_misalign(3'b011, 64'h8000_0004);
    do_misalign(3'b001, 64'h8000_0001);

    // LD to x0: full read, no write
    do_load(3'b011, 64'h8000_0018, 5'd0, 64'h1111_2222_3333_4444, 2'b00, 0, 0);

    // Reset while waiting in R
    load_valid = 1'b1; load_addr = 64'h8000_0020; load_funct3 = 3'b011; load_rd = 5'd17;
    @(posedge clk); #1 arready = 1'b1;
    @(posedge clk); #1 arready = 1'b0;
    @(negedge clk);
    chk1("pre_rst_rready", rready, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("mid_rst_stall", stall, 1'b0);
    chk1("mid_rst_arvalid", arvalid, 1'b0);
    chk1("mid_rst_rready", rready, 1'b0);
    chk1("mid_rst_wena", reg_write_ena, 1'b0);
    load_valid = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    push_wr(5'd18, 64'h0000_0000_0000_0042);
    do_load(3'b100, 64'h8000_0021, 5'd18, 64'h0000_0000_0000_4200, 2'b00, 0, 0);

    // SLVERR and DECERR responses
`ifdef LOAD_RESP_CHECK_EN
    push_fault();
    do_load(3'b011, 64'h8000_0028, 5'd16, 64'hCAFE_F00D_1234_5678, 2'b10, 0, 0);
    push_fault();
    do_load(3'b010, 64'h8000_0030, 5'd19, 64'h0000_0000_7000_0000, 2'b11, 0, 0);
`else
    push_wr(5'd16, 64'hCAFE_F00D_1234_5678);
    do_load(3'b011, 64'h8000_0028, 5'd16, 64'hCAFE_F00D_1234_5678, 2'b10, 0, 0);
    push_wr(5'd19, 64'h0000_0000_7000_0000);
    do_load(3'b010, 64'h8000_0030, 5'd19, 64'h0000_0000_7000_0000, 2'b11, 0, 0);
`endif
    @(negedge clk);
    chk1("fault_idle", load_fault, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk64("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
